// File: rtl/inst_queue_pkg.sv
// Shared core widths used by fetch, the instruction queue and decode.
package inst_queue_pkg;

    localparam int unsigned CORE_PC_W    = 8;
    localparam int unsigned CORE_INSTR_W = 32;
    localparam int unsigned IQ_DEPTH     = 8;

endpackage

// File: rtl/iq_storage.sv
// Instruction queue entry array: one synchronous write port, one asynchronous read port.
module iq_storage #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 40
) (
    input  logic                       clk,
    input  logic                       we,
    input  logic [$clog2(DEPTH)-1:0]   waddr,
    input  logic [WIDTH-1:0]           wdata,
    input  logic [$clog2(DEPTH)-1:0]   raddr,
    output logic [WIDTH-1:0]           rdata_c
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Contents are only meaningful behind valid pointers, so no reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_c = mem[raddr];

endmodule

// File: rtl/inst_queue.sv
// Fetch-to-decode instruction FIFO with flush; pointer and occupancy control lives here.
module inst_queue
    import inst_queue_pkg::*;
#(
    parameter int unsigned DEPTH   = IQ_DEPTH,
    parameter int unsigned PC_W    = CORE_PC_W,
    parameter int unsigned INSTR_W = CORE_INSTR_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    input  logic [PC_W-1:0]          in_pc,
    input  logic [INSTR_W-1:0]       in_instr,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [PC_W-1:0]          out_pc,
    output logic [INSTR_W-1:0]       out_instr,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam int unsigned ENTRY_W = PC_W + INSTR_W;

    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic [PTR_W-1:0]   head_next;
    logic [PTR_W-1:0]   tail_next;
    logic [CNT_W-1:0]   count_next;
    logic               in_ready_next;
    logic               out_valid_next;
    logic               push;
    logic               pop;
    logic [ENTRY_W-1:0] rd_entry;

    // Handshakes use only registered flags, so no ready-to-ready path exists.
    always_comb begin
        push           = in_valid && in_ready && !flush;
        pop            = out_valid && out_ready && !flush;
        head_next      = head;
        tail_next      = tail;
        count_next     = count;
        if (flush) begin
            head_next  = '0;
            tail_next  = '0;
            count_next = '0;
        end else begin
            if (push) begin
                tail_next = tail + PTR_W'(1);
            end
            if (pop) begin
                head_next = head + PTR_W'(1);
            end
            if (push && !pop) begin
                count_next = count + CNT_W'(1);
            end else if (pop && !push) begin
                count_next = count - CNT_W'(1);
            end
        end
        out_valid_next = (count_next != '0);
        in_ready_next  = (count_next != CNT_W'(DEPTH));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            head      <= head_next;
            tail      <= tail_next;
            count     <= count_next;
            out_valid <= out_valid_next;
            in_ready  <= in_ready_next;
        end
    end

    iq_storage #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_storage (
        .clk     (clk),
        .we      (push),
        .waddr   (tail),
        .wdata   ({in_pc, in_instr}),
        .raddr   (head),
        .rdata_c (rd_entry)
    );

    assign {out_pc, out_instr} = rd_entry;

endmodule

// File: tb/tb_inst_queue.sv
// Directed self-checking bench for inst_queue at default parameters.
module tb_inst_queue;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic [7:0]  in_pc;
    logic [31:0] in_instr;
    logic        in_ready;
    logic        out_valid;
    logic [7:0]  out_pc;
    logic [31:0] out_instr;
    logic        out_ready;
    logic [3:0]  count;

    int n_checks;
    int n_fail;

    inst_queue dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_pc    (out_pc),
        .out_instr (out_instr),
        .out_ready (out_ready),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge; outputs are sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [7:0] pc, input logic [31:0] instr);
        in_valid = 1'b1;
        in_pc    = pc;
        in_instr = instr;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] boot_instr [3];
        n_checks  = 0;
        n_fail    = 0;
        boot_instr[0] = 32'h0000_0013;
        boot_instr[1] = 32'h0010_0093;
        boot_instr[2] = 32'h0020_0113;
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_pc     = '0;
        in_instr  = '0;
        out_ready = 1'b0;
        #1;
        step();
        reset = 1'b0;
        check_eq("rst_count", 32'(count), 32'd0);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);

        // Three boot instructions, decode stalled.
        push_one(8'd0, boot_instr[0]);
        check_eq("latency_out_valid", 32'(out_valid), 32'd1);
        push_one(8'd1, boot_instr[1]);
        push_one(8'd2, boot_instr[2]);
        check_eq("three_count", 32'(count), 32'd3);
        check_eq("three_out_pc", 32'(out_pc), 32'd0);
        check_eq("three_out_instr", out_instr, 32'h0000_0013);

        // Fill to capacity.
        for (int i = 3; i < 8; i++) begin
            push_one(8'(i), 32'h1000_0000 | 32'(i));
        end
        check_eq("full_count", 32'(count), 32'd8);
        check_eq("full_in_ready", 32'(in_ready), 32'd0);

        // Push offered while full with a simultaneous pop: only the pop happens.
        in_valid  = 1'b1;
        in_pc     = 8'd8;
        in_instr  = 32'h1000_0008;
        out_ready = 1'b1;
        step();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check_eq("full_pop_count", 32'(count), 32'd7);
        check_eq("full_pop_head_pc", 32'(out_pc), 32'd1);
        check_eq("full_pop_head_instr", out_instr, 32'h0010_0093);
        check_eq("full_pop_in_ready", 32'(in_ready), 32'd1);

        // Drain and confirm order; the refused pc 8 must never appear.
        out_ready = 1'b1;
        for (int i = 1; i < 8; i++) begin
            check_eq($sformatf("drain_pc%0d", i), 32'(out_pc), 32'(i));
            step();
        end
        out_ready = 1'b0;
        check_eq("drain_count", 32'(count), 32'd0);
        check_eq("drain_out_valid", 32'(out_valid), 32'd0);

        // Streaming push+pop across pointer wrap.
        push_one(8'd0, 32'h2000_0000);
        for (int k = 1; k < 20; k++) begin
            in_valid  = 1'b1;
            in_pc     = 8'(k);
            in_instr  = 32'h2000_0000 | 32'(k);
            out_ready = 1'b1;
            check_eq($sformatf("stream_pc%0d", k - 1), 32'(out_pc), 32'(k - 1));
            step();
            check_eq($sformatf("stream_count%0d", k), 32'(count), 32'd1);
        end
        in_valid = 1'b0;
        check_eq("stream_pc19", 32'(out_pc), 32'd19);
        check_eq("stream_instr19", out_instr, 32'h2000_0013);
        step();
        out_ready = 1'b0;
        check_eq("stream_end_count", 32'(count), 32'd0);

        // Flush overrides simultaneous push and pop.
        for (int i = 0; i < 5; i++) begin
            push_one(8'h40 + 8'(i), 32'h3000_0000 | 32'(i));
        end
        check_eq("pre_flush_count", 32'(count), 32'd5);
        flush     = 1'b1;
        in_valid  = 1'b1;
        in_pc     = 8'h99;
        in_instr  = 32'hDEAD_BEEF;
        out_ready = 1'b1;
        step();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check_eq("flush_count", 32'(count), 32'd0);
        check_eq("flush_out_valid", 32'(out_valid), 32'd0);
        check_eq("flush_in_ready", 32'(in_ready), 32'd1);
        push_one(8'h77, 32'h3000_0077);
        check_eq("post_flush_pc", 32'(out_pc), 32'h77);
        check_eq("post_flush_count", 32'(count), 32'd1);

        // Reset mid-stream wins over push and pop.
        for (int i = 0; i < 3; i++) begin
            push_one(8'h50 + 8'(i), 32'h4000_0000 | 32'(i));
        end
        check_eq("pre_reset_count", 32'(count), 32'd4);
        reset     = 1'b1;
        in_valid  = 1'b1;
        in_pc     = 8'h66;
        out_ready = 1'b1;
        step();
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check_eq("mid_rst_count", 32'(count), 32'd0);
        check_eq("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("mid_rst_in_ready", 32'(in_ready), 32'd1);
        push_one(8'h2A, 32'h0000_002A);
        check_eq("after_rst_out_valid", 32'(out_valid), 32'd1);
        check_eq("after_rst_pc", 32'(out_pc), 32'h2A);
        check_eq("after_rst_count", 32'(count), 32'd1);

        // Empty queue ignores out_ready; head must not move.
        out_ready = 1'b1;
        step();
        check_eq("empty_count0", 32'(count), 32'd0);
        for (int i = 1; i <= 3; i++) begin
            step();
            check_eq($sformatf("empty_count%0d", i), 32'(count), 32'd0);
            check_eq($sformatf("empty_out_valid%0d", i), 32'(out_valid), 32'd0);
        end
        out_ready = 1'b0;
        push_one(8'h55, 32'h0000_0055);
        check_eq("no_underflow_pc", 32'(out_pc), 32'h55);
        check_eq("no_underflow_count", 32'(count), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
